// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the MIPS program-counter block.
package mips_pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  // Legacy-compatible encodings used by the registered FSM
  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
  localparam int unsigned PC_INC           = 4;

  function automatic logic f_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC calculation for the RUN state: redirect targets, strict priority
// select and misaligned-target trap detection.
module pc_next_sel
  import mips_pc_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_pc_plus4,
  input  logic [WIDTH-1:0] i_epc,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [15:0]      i_branch_imm,
  input  logic             i_jump,
  input  logic [25:0]      i_jump_index,
  input  logic             i_jump_reg,
  input  logic [WIDTH-1:0] i_jr_target,
  input  logic             i_exception,
  input  logic             i_eret,
  input  logic             i_halt,
  output logic [WIDTH-1:0] o_next_pc,
  output logic             o_take_trap,
  output logic             o_misaligned,
  output logic             o_halt_req,
  output logic [WIDTH-1:0] o_bad_target
);

  localparam logic [WIDTH-1:0] EXC_W = WIDTH'(EXC_VECTOR);

  logic [WIDTH-1:0] w_br_off;
  logic [WIDTH-1:0] w_br_target;
  logic [WIDTH-1:0] w_j_target;
  logic [WIDTH-1:0] w_target;
  logic             w_redir;
  logic             w_bad;

  assign w_br_off    = {{(WIDTH-18){i_branch_imm[15]}}, i_branch_imm, 2'b00};
  assign w_br_target = i_pc_plus4 + w_br_off;
  assign w_j_target  = {i_pc_plus4[WIDTH-1:28], i_jump_index, 2'b00};

  always_comb begin
    w_redir  = 1'b0;
    w_target = i_pc_plus4;
    if (i_jump_reg) begin
      w_redir  = 1'b1;
      w_target = i_jr_target;
    end else if (i_jump) begin
      w_redir  = 1'b1;
      w_target = w_j_target;
    end else if (i_branch_taken) begin
      w_redir  = 1'b1;
      w_target = w_br_target;
    end else begin
      w_redir  = 1'b0;
      w_target = i_pc_plus4;
    end
  end

  assign w_bad        = w_redir && f_misaligned(w_target[1:0]);
  assign o_bad_target = w_target;

  // Stall drops redirects outright, so a bad target under stall never traps
  always_comb begin
    o_next_pc    = i_pc_plus4;
    o_take_trap  = 1'b0;
    o_misaligned = 1'b0;
    o_halt_req   = 1'b0;
    if (i_exception) begin
      o_next_pc   = EXC_W;
      o_take_trap = 1'b1;
    end else if (i_eret) begin
      o_next_pc = i_epc;
    end else if (i_halt) begin
      o_next_pc  = i_pc;
      o_halt_req = 1'b1;
    end else if (i_stall) begin
      o_next_pc = i_pc;
    end else if (w_bad) begin
      o_next_pc    = EXC_W;
      o_take_trap  = 1'b1;
      o_misaligned = 1'b1;
    end else begin
      o_next_pc = w_target;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter block: PC/EPC/BadVAddr registers and the BOOT/RUN/HALTED FSM.
module pc_unit
  import mips_pc_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [15:0]      branch_imm,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exception,
  input  logic             eret,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] badvaddr,
  output logic             misaligned,
  output logic [1:0]       state
);

  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_W = WIDTH'(EXC_VECTOR);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic [WIDTH-1:0] r_badvaddr;
  logic             r_misaligned;
  logic [1:0]       r_state;

  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_bad_target;
  logic             w_take_trap;
  logic             w_misaligned;
  logic             w_halt_req;

  assign w_pc_plus4 = r_pc + WIDTH'(PC_INC);

  pc_next_sel #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_sel (
    .i_pc           (r_pc),
    .i_pc_plus4     (w_pc_plus4),
    .i_epc          (r_epc),
    .i_stall        (stall),
    .i_branch_taken (branch_taken),
    .i_branch_imm   (branch_imm),
    .i_jump         (jump),
    .i_jump_index   (jump_index),
    .i_jump_reg     (jump_reg),
    .i_jr_target    (jr_target),
    .i_exception    (exception),
    .i_eret         (eret),
    .i_halt         (halt),
    .o_next_pc      (w_next_pc),
    .o_take_trap    (w_take_trap),
    .o_misaligned   (w_misaligned),
    .o_halt_req     (w_halt_req),
    .o_bad_target   (w_bad_target)
  );

  // Misaligned is a pulse: cleared every cycle unless a trap sets it again
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RST_W;
      r_epc        <= '0;
      r_badvaddr   <= '0;
      r_misaligned <= 1'b0;
      r_state      <= ST_BOOT;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_pc <= w_next_pc;
          if (w_take_trap) r_epc <= r_pc;
          if (w_misaligned) begin
            r_badvaddr   <= w_bad_target;
            r_misaligned <= 1'b1;
          end
          if (w_halt_req) r_state <= ST_HALTED;
        end
        ST_HALTED: begin
          if (exception) begin
            r_epc   <= r_pc;
            r_pc    <= EXC_W;
            r_state <= ST_RUN;
          end else if (resume) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign fetch_valid = (r_state == ST_RUN) && !stall;
  assign epc         = r_epc;
  assign badvaddr    = r_badvaddr;
  assign misaligned  = r_misaligned;
  assign state       = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed per-cycle vectors push expected
// observations; a negedge monitor pops and compares them.
module tb_pc_unit;

  localparam logic [31:0] EV = 32'h8000_0180;
  localparam logic [1:0]  SB = 2'd0;
  localparam logic [1:0]  SR = 2'd1;
  localparam logic [1:0]  SH = 2'd2;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] imm;
    logic        jmp;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jrt;
    logic        exc;
    logic        eret;
    logic        halt;
    logic        resume;
  } in_t;

  typedef struct {
    string       name;
    int          due;
    logic [31:0] pc;
    logic        fv;
    logic [31:0] epc;
    logic [31:0] bad;
    logic        mis;
    logic [1:0]  st;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jump_reg, exception, eret, halt, resume;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] pc, pc_plus4, epc, badvaddr;
  logic        fetch_valid, misaligned;
  logic [1:0]  state;

  int   cycle_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  pc_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .jump(jump), .jump_index(jump_index),
    .jump_reg(jump_reg), .jr_target(jr_target), .exception(exception),
    .eret(eret), .halt(halt), .resume(resume), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .epc(epc), .badvaddr(badvaddr),
    .misaligned(misaligned), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic in_t f_idle();
    in_t v; v = '0; return v;
  endfunction
  function automatic in_t f_rst();
    in_t v; v = '0; v.rst = 1'b1; return v;
  endfunction
  function automatic in_t f_stall();
    in_t v; v = '0; v.stall = 1'b1; return v;
  endfunction
  function automatic in_t f_br(input logic [15:0] imm);
    in_t v; v = '0; v.br = 1'b1; v.imm = imm; return v;
  endfunction
  function automatic in_t f_jmp(input logic [25:0] idx);
    in_t v; v = '0; v.jmp = 1'b1; v.idx = idx; return v;
  endfunction
  function automatic in_t f_jr(input logic [31:0] t);
    in_t v; v = '0; v.jr = 1'b1; v.jrt = t; return v;
  endfunction
  function automatic in_t f_exc();
    in_t v; v = '0; v.exc = 1'b1; return v;
  endfunction
  function automatic in_t f_eret();
    in_t v; v = '0; v.eret = 1'b1; return v;
  endfunction
  function automatic in_t f_halt();
    in_t v; v = '0; v.halt = 1'b1; return v;
  endfunction
  function automatic in_t f_resume();
    in_t v; v = '0; v.resume = 1'b1; return v;
  endfunction

  // Apply inputs for one cycle; expectations describe what is seen this cycle
  task automatic run(input string nm, input bit chk, input in_t i,
                     input logic [31:0] e_pc, input logic e_fv,
                     input logic [31:0] e_epc, input logic [31:0] e_bad,
                     input logic e_mis, input logic [1:0] e_st);
    exp_t e;
    reset = i.rst; stall = i.stall; branch_taken = i.br; branch_imm = i.imm;
    jump = i.jmp; jump_index = i.idx; jump_reg = i.jr; jr_target = i.jrt;
    exception = i.exc; eret = i.eret; halt = i.halt; resume = i.resume;
    if (chk) begin
      e.name = nm; e.due = cycle_cnt; e.pc = e_pc; e.fv = e_fv;
      e.epc = e_epc; e.bad = e_bad; e.mis = e_mis; e.st = e_st;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every observation that falls due this cycle
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cycle_cnt) begin
      exp_t e;
      logic [31:0] e_p4;
      e = sb_q.pop_front();
      n_tests++;
      e_p4 = e.pc + 32'd4;
      if (e.due != cycle_cnt) begin
        n_fail++;
        $display("FAIL %s: observation missed (due %0d, now %0d)", e.name, e.due, cycle_cnt);
      end else if (pc !== e.pc || pc_plus4 !== e_p4 || fetch_valid !== e.fv ||
                   epc !== e.epc || badvaddr !== e.bad || misaligned !== e.mis ||
                   state !== e.st) begin
        n_fail++;
        $display("FAIL %s: got pc=%h p4=%h fv=%b epc=%h bad=%h mis=%b st=%0d, expected pc=%h p4=%h fv=%b epc=%h bad=%h mis=%b st=%0d",
                 e.name, pc, pc_plus4, fetch_valid, epc, badvaddr, misaligned, state,
                 e.pc, e_p4, e.fv, e.epc, e.bad, e.mis, e.st);
      end
    end
  end

  initial begin
    run("rst0",      1'b0, f_rst(),  32'h0, 1'b0, 32'h0, 32'h0, 1'b0, SB);
    run("rst1",      1'b1, f_rst(),  32'h0, 1'b0, 32'h0, 32'h0, 1'b0, SB);
    run("boot",      1'b1, f_idle(), 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, SB);
    run("run0",      1'b1, f_idle(), 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, SR);
    run("seq4",      1'b1, f_idle(), 32'h4, 1'b1, 32'h0, 32'h0, 1'b0, SR);
    run("seq8",      1'b1, f_jr(32'h100), 32'h8, 1'b1, 32'h0, 32'h0, 1'b0, SR);
    run("jr100",     1'b1, f_br(16'hFFFE), 32'h100, 1'b1, 32'h0, 32'h0, 1'b0, SR);
    run("br_back",   1'b1, f_jr(32'h0040_0010), 32'h0FC, 1'b1, 32'h0, 32'h0, 1'b0, SR);
    run("jr400010",  1'b1, f_jmp(26'h10), 32'h0040_0010, 1'b1, 32'h0, 32'h0, 1'b0, SR);
    run("jump",      1'b1, f_jr(32'h200), 32'h40, 1'b1, 32'h0, 32'h0, 1'b0, SR);
    run("jr200",     1'b1, f_jr(32'h302), 32'h200, 1'b1, 32'h0, 32'h0, 1'b0, SR);
    run("mis_trap",  1'b1, f_idle(), EV, 1'b1, 32'h200, 32'h302, 1'b1, SR);
    run("mis_pulse", 1'b1, f_idle(), 32'h8000_0184, 1'b1, 32'h200, 32'h302, 1'b0, SR);
    run("exc_seq",   1'b1, f_jr(32'h50), 32'h8000_0188, 1'b1, 32'h200, 32'h302, 1'b0, SR);
    run("jr50",      1'b1, f_exc(), 32'h50, 1'b1, 32'h200, 32'h302, 1'b0, SR);
    run("exc_in",    1'b1, f_idle(), EV, 1'b1, 32'h50, 32'h302, 1'b0, SR);
    run("exc_seq2",  1'b1, f_eret(), 32'h8000_0184, 1'b1, 32'h50, 32'h302, 1'b0, SR);
    run("eret",      1'b1, f_idle(), 32'h50, 1'b1, 32'h50, 32'h302, 1'b0, SR);
    run("post_eret", 1'b1, f_jr(32'h60), 32'h54, 1'b1, 32'h50, 32'h302, 1'b0, SR);
    run("jr60",      1'b1, f_exc() | f_eret(), 32'h60, 1'b1, 32'h50, 32'h302, 1'b0, SR);
    run("exc_eret",  1'b1, f_eret() | f_stall(), EV, 1'b0, 32'h60, 32'h302, 1'b0, SR);
    run("eret_stl",  1'b1, f_stall() | f_br(16'h0010), 32'h60, 1'b0, 32'h60, 32'h302, 1'b0, SR);
    run("stall2",    1'b1, f_stall() | f_br(16'h0010), 32'h60, 1'b0, 32'h60, 32'h302, 1'b0, SR);
    run("stall3",    1'b1, f_stall() | f_br(16'h0010), 32'h60, 1'b0, 32'h60, 32'h302, 1'b0, SR);
    run("br_drop",   1'b1, f_halt(), 32'h60, 1'b1, 32'h60, 32'h302, 1'b0, SR);
    run("halted",    1'b1, f_idle(), 32'h60, 1'b0, 32'h60, 32'h302, 1'b0, SH);
    run("halt_hold", 1'b1, f_halt() | f_resume(), 32'h60, 1'b0, 32'h60, 32'h302, 1'b0, SH);
    run("resumed",   1'b1, f_halt(), 32'h60, 1'b1, 32'h60, 32'h302, 1'b0, SR);
    run("halted2",   1'b1, f_exc(), 32'h60, 1'b0, 32'h60, 32'h302, 1'b0, SH);
    run("halt_exc",  1'b1, f_stall() | f_exc(), EV, 1'b0, 32'h60, 32'h302, 1'b0, SR);
    run("stall_exc", 1'b1, f_jr(32'hFFFF_FFFC), EV, 1'b1, EV, 32'h302, 1'b0, SR);
    run("top",       1'b1, f_idle(), 32'hFFFF_FFFC, 1'b1, EV, 32'h302, 1'b0, SR);
    run("wrap",      1'b1, f_jr(32'h1234), 32'h0, 1'b1, EV, 32'h302, 1'b0, SR);
    run("jr1234",    1'b1, f_rst() | f_exc(), 32'h1234, 1'b1, EV, 32'h302, 1'b0, SR);
    run("mid_rst",   1'b1, f_exc(), 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, SB);
    run("boot_ign",  1'b1, f_idle(), 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, SR);
    run("tail",      1'b1, f_idle(), 32'h4, 1'b1, 32'h0, 32'h0, 1'b0, SR);
    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d observations never compared, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter block for the monocycle/multicycle MIPS datapath. It generalises the plain PC register.
- Adds: configurable width and vectors, stall, prioritised redirect (branch, jump, jump-register), exception entry and return (EPC), misaligned-target trapping, and a BOOT/RUN/HALTED control FSM.
- Sits between the control unit/ALU branch logic and instruction memory.

Parameters:
- WIDTH, 32, address width in bits; legal values are WIDTH >= 32.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (zero-extended to WIDTH).
- EXC_VECTOR, 32'h8000_0180, PC value loaded on exception entry (zero-extended to WIDTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC this cycle (hazard or memory wait).
- branch_taken  in  1  conditional branch resolved taken.
- branch_imm  in  16  branch immediate, in words, signed.
- jump  in  1  J/JAL redirect.
- jump_index  in  26  instr[25:0] for J/JAL.
- jump_reg  in  1  JR/JALR redirect.
- jr_target  in  WIDTH  register-sourced target.
- exception  in  1  take exception this cycle.
- eret  in  1  return from exception.
- halt  in  1  enter HALTED.
- resume  in  1  leave HALTED.
- pc  out  WIDTH  current PC.
- pc_plus4  out  WIDTH  pc + 4, combinational, wraps modulo 2^WIDTH.
- fetch_valid  out  1  the current pc is a live fetch.
- epc  out  WIDTH  exception PC.
- badvaddr  out  WIDTH  offending misaligned target.
- misaligned  out  1  one-cycle pulse when a misaligned trap is taken.
- state  out  2  FSM state (BOOT=0, RUN=1, HALTED=2).

Behaviour:
- Reset (synchronous, overrides all inputs, including mid-redirect):
  - pc=RESET_VECTOR, epc=0, badvaddr=0, misaligned=0, state=BOOT.
- BOOT:
  - fetch_valid=0, pc holds.
  - Unconditionally moves to RUN on the next edge.
  - All other inputs are ignored.
- RUN:
  - fetch_valid = !stall.
  - Next pc is chosen by strict priority; the first match wins:
    1. exception: epc<=pc, pc<=EXC_VECTOR.
    2. eret: pc<=epc.
    3. halt: state<=HALTED, pc holds.
    4. stall: pc holds. Redirect inputs are dropped; the control unit must re-assert them.
    5. jump_reg: target = jr_target.
    6. jump: target = {pc_plus4[WIDTH-1:28], jump_index, 2'b00}.
    7. branch_taken: target = pc_plus4 + (sign_extend(branch_imm) << 2), modulo 2^WIDTH.
    8. Otherwise: pc <= pc_plus4, wrapping from all-ones-minus-3 to 0.
- Misaligned target (rules 5–7 only, when target[1:0] != 0):
  - pc<=EXC_VECTOR, epc<=pc, badvaddr<=target, misaligned=1 for exactly one cycle.
  - The jr_target rule is the only source that can produce this; branch and jump targets are always aligned by construction.
- HALTED:
  - fetch_valid=0, pc holds.
  - exception takes priority: epc<=pc, pc<=EXC_VECTOR, state<=RUN.
  - Otherwise resume: state<=RUN, pc holds.
  - halt+resume asserted together: resume wins.
- Simultaneous events:
  - exception+eret: exception wins; epc is overwritten.
  - stall+exception: exception wins.
- Latency: every redirect takes effect at the next rising edge, with no bubble cycles inserted by this block.
- epc and badvaddr change only on trap entry or reset.

Decomposition:
- Package mips_pc_pkg holds:
  - the pc_state_t enum {BOOT, RUN, HALTED};
  - default RESET_VECTOR and EXC_VECTOR constants;
  - localparam PC_INC = 4.
- Sub-module pc_next_sel is natural: combinational target calculation, priority select, and misalignment check.
  - Inputs: pc, the redirect inputs, epc.
  - Outputs: next_pc, take_trap, bad_target.
- pc_unit keeps the registers and the FSM.

Test Plan:
- Reset then free-run: reset for 2 cycles → pc=0, state=BOOT, fetch_valid=0. Next cycle: state=RUN, pc=0. Following cycles: pc=4, 8, 12.
- Branch and jump: at pc=0x100, branch_taken with imm=16'hFFFE → pc=0x0FC. At pc=0x0040_0010, jump with index=0x10 → pc=0x0000_0040.
- Misaligned JR: at pc=0x200, jump_reg with jr_target=0x302 → pc=0x8000_0180, epc=0x200, badvaddr=0x302, misaligned=1 for one cycle only.
- Exception/eret round trip: exception at pc=0x50 → pc=0x8000_0180, epc=0x50. Later eret → pc=0x50. exception+eret together at pc=0x60 → epc=0x60.
- Stall/halt: stall for 3 cycles with branch_taken asserted → pc unchanged, fetch_valid=0, branch dropped. halt → HALTED. Exception while HALTED → RUN, pc=0x8000_0180.
- Wrap and mid-op reset: pc=0xFFFF_FFFC sequential → pc=0. reset asserted together with exception → pc=0, epc=0, state=BOOT.
